fetch_pc_unit: RTL
==================

# fetch_pc_unit

Instruction-fetch front end that consumes the branch/jump redirect decision (PCSrc plus target) produced in EX and owns the program counter. It issues one instruction-memory request at a time with a valid/ready handshake and presents fetched instructions to decode through a single-entry output register. On a redirect it flushes the output register and discards any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- XLEN, 32, PC and instruction width
---
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- redirect  in  1  PCSrc from EX; 1 = take redirect_target
- redirect_target  in  XLEN  branch/jump target address
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (current PC)
- imem_rsp_valid  in  1  response valid; no backpressure
- imem_rsp_instr  in  XLEN  fetched instruction
- if_valid  out  1  output register holds an instruction
- if_ready  in  1  decode consumes (i.e. not stalled)
- if_pc  out  XLEN  PC of held instruction
- if_instr  out  XLEN  held instruction

## Operation
- States: IDLE, FETCH, WAIT, DROP. Reset: state IDLE, pc = RESET_PC, if_valid = 0, if_pc = 0, if_instr = 0.
- IDLE: unconditionally to FETCH next cycle; imem_req_valid = 0.
- FETCH: imem_req_valid = ~redirect & (~if_valid | if_ready); imem_req_addr = pc. Accept (valid & ready) -> WAIT.
- WAIT: on imem_rsp_valid load if_pc = pc, if_instr = imem_rsp_instr, if_valid = 1, pc = pc + 4 (mod 2^XLEN), -> FETCH.
- Output register: if_valid & if_ready clears if_valid unless reloaded in the same cycle.
- Redirect (highest priority, any state except IDLE): pc = redirect_target, if_valid = 0 next cycle.
  - FETCH: no request issued that cycle; stay FETCH.
  - WAIT with imem_rsp_valid same cycle: response discarded, -> FETCH.
  - WAIT without response: -> DROP.
  - DROP: stay DROP, pc updated again (latest target wins).
- DROP: imem_req_valid = 0; on imem_rsp_valid discard response, -> FETCH.
- Only one outstanding request ever; the issue gate guarantees the output slot is empty when the response arrives, so no response is lost.

## Timing
- Response arrives no earlier than the cycle after acceptance; minimum 2 cycles per instruction.
- Reset to first imem_req_valid: 2 cycles after rst_n deasserts (IDLE, then FETCH).
- Redirect to request at new target: next cycle if in FETCH/WAIT-with-response; one cycle after the stale response if DROP.
- if_valid deasserts the cycle after redirect; decode never sees a wrong-path instruction after that edge.
- rst_n assertion mid-transaction: immediate return to reset values; a response arriving after reset release is ignored only if it arrives while in IDLE; memory must be reset together.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_redirects and perf_stall_cycles (32 bits each, reset 0, saturating at all-ones). perf_redirects increments on every redirect cycle outside IDLE; perf_stall_cycles increments every cycle if_valid & ~if_ready.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- fetch_pkg: state enum (IDLE, FETCH, WAIT, DROP), default RESET_PC constant, PC increment constant 4.
- Sub-module fetch_perf_ctr (saturating 32-bit counter with enable), instantiated twice under FETCH_PERF_EN.

## Test plan
- Reset release, req_ready = 1, 1-cycle memory -> requests at 0x0, 0x4, 0x8; if_pc matches, if_instr matches memory.
- Hold if_ready = 0 for 5 cycles with instruction at 0x4 held -> no new request issued, if_pc stays 0x4; release -> request 0x8 same cycle.
- Redirect to 0x100 in WAIT, response 3 cycles later -> DROP, stale instr never on if_instr, next request 0x100.
- Redirect to 0x200 in the same cycle as imem_rsp_valid -> response dropped, next request 0x200, if_valid 0.
- Two redirects in DROP (0x300 then 0x400) -> first post-DROP request 0x400.
- FETCH_PERF_EN: 3 redirects, 7 stall cycles -> perf_redirects = 3, perf_stall_cycles = 7; rst_n low -> both 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Fetch FSM states, default reset PC and the sequential PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DROP
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_INC       = 4;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch unit bus: imem request/response plus the decode-facing register.
// master = fetch unit side, slave = memory/decode side.
interface fetch_pc_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_instr;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_instr,
    output if_valid,
    output if_pc,
    output if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_instr,
    input  if_valid,
    input  if_pc,
    input  if_instr,
    output if_ready
  );

endinterface

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter with enable.
// Sticks at all-ones instead of wrapping.
module fetch_perf_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC owner and single-outstanding imem fetcher with redirect flush.
// Optional FETCH_PERF_EN adds redirect and stall counters.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  fetch_pc_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_stall_cycles
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inc;
  logic            vld_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            slot_free;
  logic            req_valid;
  logic            req_fire;
  logic            rsp;

  // Issue only when the slot will be empty by response time.
  assign slot_free = ~vld_q | bus.if_ready;
  assign req_valid = (state == FETCH) & ~redirect & slot_free;
  assign req_fire  = req_valid & bus.imem_req_ready;
  assign rsp       = bus.imem_rsp_valid;
  assign pc_inc    = pc + XLEN'(PC_INC);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = vld_q;
  assign bus.if_pc          = pc_q;
  assign bus.if_instr       = instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      vld_q   <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      if (vld_q && bus.if_ready) begin
        vld_q <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            pc    <= redirect_target;
            vld_q <= 1'b0;
          end else if (req_fire) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc    <= redirect_target;
            vld_q <= 1'b0;
            state <= rsp ? FETCH : DROP;
          end else if (rsp) begin
            pc_q    <= pc;
            instr_q <= bus.imem_rsp_instr;
            vld_q   <= 1'b1;
            pc      <= pc_inc;
            state   <= FETCH;
          end
        end
        DROP: begin
          if (redirect) begin
            pc    <= redirect_target;
            vld_q <= 1'b0;
          end
          // The stale response retires the outstanding request.
          if (rsp) begin
            state <= FETCH;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_ctr #(.W(32)) u_redir_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (redirect & (state != IDLE)),
    .count (perf_redirects)
  );

  fetch_perf_ctr #(.W(32)) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (vld_q & ~bus.if_ready),
    .count (perf_stall_cycles)
  );
`endif

endmodule
